order_stream_tx: RTL and testbench
==================================

ORDER_STREAM_TX -- requirements
Module: order_stream_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter GO_GAP, default 3, minimum idle clk cycles after every go pulse (>=1).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  FIFO can accept a command.
REQ-007 cmd_is_exchange  input  1  1 = exchange channel, 0 = cpu channel.
REQ-008 cmd_new_max  input  1  new-max flag (cpu channel only).
REQ-009 cmd_client_id  input  5  target client.
REQ-010 cmd_amount  input  32  order amount.
REQ-011 cpu_go  output  1  one-cycle cpu transaction strobe.
REQ-012 cpu_new_max  output  1  held cpu new-max flag.
REQ-013 cpu_client_id  output  5  held cpu client id.
REQ-014 cpu_amount  output  32  held cpu amount.
REQ-015 exchange_go  output  1  one-cycle exchange transaction strobe.
REQ-016 exchange_client_id  output  5  held exchange client id.
REQ-017 exchange_amount  output  16  held exchange amount (saturated).
REQ-018 exchange_sat  output  1  pulses with exchange_go when amount was saturated.
REQ-019 issued_count  output  16  total go pulses issued, wraps.

Function
REQ-020 Command accepted on a posedge where cmd_valid && cmd_ready; cmd_ready = FIFO not full (no bypass; full FIFO never accepts, even on a same-cycle pop).
REQ-021 Commands issue strictly in acceptance order across both channels.
REQ-022 FSM states IDLE, ISSUE, GAP; IDLE->ISSUE when FIFO non-empty; ISSUE->GAP always; GAP lasts exactly GO_GAP cycles then ->ISSUE if non-empty else ->IDLE.
REQ-023 In ISSUE the head entry is popped and exactly one of cpu_go/exchange_go is high for that one cycle, selected by its cmd_is_exchange.
REQ-024 Channel data outputs update only on their own go cycle and hold until the next go on that channel; the other channel's outputs are untouched.
REQ-025 Latency: command accepted at edge k into empty FIFO in IDLE -> go high in cycle after edge k+2.
REQ-026 Back-to-back go pulses are spaced exactly GO_GAP+1 cycles when FIFO stays non-empty.
REQ-027 exchange_amount = cmd_amount[15:0] if cmd_amount <= 0xFFFF else 0xFFFF with exchange_sat=1; cpu path passes 32 bits unmodified; cmd_new_max ignored for exchange commands.
REQ-028 issued_count increments by 1 on every go pulse, 0xFFFF wraps to 0x0000.
REQ-029 Simultaneous push and pop (non-full FIFO) keeps occupancy unchanged.

Reset
REQ-030 rst flushes FIFO, forces IDLE, clears GAP counter, mid-operation included; no go pulse in the cycle after rst deasserts.
REQ-031 All outputs reset to 0, except cmd_ready = 1 after reset.

Structure
REQ-032 Package order_stream_pkg holds FSM state enum, CLIENT_W=5, CPU_AMT_W=32, EXCH_AMT_W=16, EXCH_AMT_MAX=16'hFFFF, default GO_GAP.
REQ-033 Storage in sub-module order_fifo (sync FIFO, single clock, full/empty flags); FSM, saturation and counter in order_stream_tx.

Verification
REQ-034 Single cpu cmd (id 3, amount 0x12345678, new_max 1) at edge k -> cpu_go at k+2 with those values, exchange_go 0, issued_count 1.
REQ-035 Exchange cmd amount 0x0001_0000 -> exchange_amount 0xFFFF, exchange_sat 1; amount 0xFFFF -> 0xFFFF, exchange_sat 0.
REQ-036 Five cmds pushed back-to-back, GO_GAP=3 -> cmd_ready low after fourth, go pulses spaced 4 cycles, in order, alternating channels as pushed.
REQ-037 rst asserted while FIFO holds 3 entries in GAP -> FIFO empty, all outputs 0, no go afterwards until new cmd.
REQ-038 Preload issued_count near wrap (65535 cmds or forced) -> next go yields issued_count 0.

Source files
------------

// File: rtl/order_stream_pkg.sv
// Shared types and constants for the order stream transmitter: command layout,
// channel widths, FSM states and the exchange-amount saturation helper.
package order_stream_pkg;

  localparam int CLIENT_W       = 5;
  localparam int CPU_AMT_W      = 32;
  localparam int EXCH_AMT_W     = 16;
  localparam int COUNT_W        = 16;
  localparam int GO_GAP_DEFAULT = 3;
  localparam logic [EXCH_AMT_W-1:0] EXCH_AMT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic                 is_exchange;
    logic                 new_max;
    logic [CLIENT_W-1:0]  client_id;
    logic [CPU_AMT_W-1:0] amount;
  } cmd_t;

  typedef struct packed {
    logic                  sat;
    logic [EXCH_AMT_W-1:0] amount;
  } exch_amt_t;

  // Anything that does not fit the narrow exchange field clamps to its maximum.
  function automatic exch_amt_t saturate_amount(input logic [CPU_AMT_W-1:0] amt);
    exch_amt_t r;
    if (amt[CPU_AMT_W-1:EXCH_AMT_W] != '0) begin
      r.sat    = 1'b1;
      r.amount = EXCH_AMT_MAX;
    end else begin
      r.sat    = 1'b0;
      r.amount = amt[EXCH_AMT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/order_stream_tx_if.sv
// Host command port and the two downstream transaction channels of order_stream_tx.
interface order_stream_tx_if;
  import order_stream_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_is_exchange;
  logic                  cmd_new_max;
  logic [CLIENT_W-1:0]   cmd_client_id;
  logic [CPU_AMT_W-1:0]  cmd_amount;

  logic                  cpu_go;
  logic                  cpu_new_max;
  logic [CLIENT_W-1:0]   cpu_client_id;
  logic [CPU_AMT_W-1:0]  cpu_amount;

  logic                  exchange_go;
  logic [CLIENT_W-1:0]   exchange_client_id;
  logic [EXCH_AMT_W-1:0] exchange_amount;
  logic                  exchange_sat;

  logic [COUNT_W-1:0]    issued_count;

  modport master (
    output cmd_valid, cmd_is_exchange, cmd_new_max, cmd_client_id, cmd_amount,
    input  cmd_ready,
    input  cpu_go, cpu_new_max, cpu_client_id, cpu_amount,
    input  exchange_go, exchange_client_id, exchange_amount, exchange_sat,
    input  issued_count
  );

  modport slave (
    input  cmd_valid, cmd_is_exchange, cmd_new_max, cmd_client_id, cmd_amount,
    output cmd_ready,
    output cpu_go, cpu_new_max, cpu_client_id, cpu_amount,
    output exchange_go, exchange_client_id, exchange_amount, exchange_sat,
    output issued_count
  );

endinterface

// File: rtl/order_fifo.sv
// Single-clock command FIFO with first-word-fall-through head and full/empty flags.
module order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // The extra pointer bit tells a full ring from an empty one.
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  assign head_o   = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/order_stream_tx.sv
// Drains queued host commands onto the cpu or exchange channel, one go strobe at a
// time with a fixed idle gap, saturating exchange amounts and counting issues.
module order_stream_tx
  import order_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GO_GAP     = GO_GAP_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  order_stream_tx_if.slave  bus
);

  localparam int GAP_W = (GO_GAP > 1) ? $clog2(GO_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GO_GAP - 1);

  cmd_t      push_cmd, head_cmd;
  exch_amt_t head_sat;
  logic      fifo_full, fifo_empty, pop;

  state_e                state_q, state_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  cpu_go_q, cpu_go_d;
  logic                  cpu_new_max_q, cpu_new_max_d;
  logic [CLIENT_W-1:0]   cpu_id_q, cpu_id_d;
  logic [CPU_AMT_W-1:0]  cpu_amt_q, cpu_amt_d;
  logic                  exch_go_q, exch_go_d;
  logic [CLIENT_W-1:0]   exch_id_q, exch_id_d;
  logic [EXCH_AMT_W-1:0] exch_amt_q, exch_amt_d;
  logic                  exch_sat_q, exch_sat_d;
  logic [COUNT_W-1:0]    issued_q, issued_d;

  assign push_cmd = '{is_exchange: bus.cmd_is_exchange, new_max: bus.cmd_new_max,
                      client_id: bus.cmd_client_id, amount: bus.cmd_amount};

  order_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.cmd_valid),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .head_o      (head_cmd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head_sat = saturate_amount(head_cmd.amount);

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    pop           = 1'b0;
    cpu_go_d      = 1'b0;
    exch_go_d     = 1'b0;
    exch_sat_d    = 1'b0;
    cpu_new_max_d = cpu_new_max_q;
    cpu_id_d      = cpu_id_q;
    cpu_amt_d     = cpu_amt_q;
    exch_id_d     = exch_id_q;
    exch_amt_d    = exch_amt_q;
    issued_d      = issued_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        pop      = 1'b1;
        state_d  = ST_GAP;
        gap_d    = '0;
        issued_d = issued_q + COUNT_W'(1);
        if (head_cmd.is_exchange) begin
          exch_go_d  = 1'b1;
          exch_id_d  = head_cmd.client_id;
          exch_amt_d = head_sat.amount;
          exch_sat_d = head_sat.sat;
        end else begin
          cpu_go_d      = 1'b1;
          cpu_new_max_d = head_cmd.new_max;
          cpu_id_d      = head_cmd.client_id;
          cpu_amt_d     = head_cmd.amount;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gap_q         <= '0;
      cpu_go_q      <= 1'b0;
      cpu_new_max_q <= 1'b0;
      cpu_id_q      <= '0;
      cpu_amt_q     <= '0;
      exch_go_q     <= 1'b0;
      exch_id_q     <= '0;
      exch_amt_q    <= '0;
      exch_sat_q    <= 1'b0;
      issued_q      <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      cpu_go_q      <= cpu_go_d;
      cpu_new_max_q <= cpu_new_max_d;
      cpu_id_q      <= cpu_id_d;
      cpu_amt_q     <= cpu_amt_d;
      exch_go_q     <= exch_go_d;
      exch_id_q     <= exch_id_d;
      exch_amt_q    <= exch_amt_d;
      exch_sat_q    <= exch_sat_d;
      issued_q      <= issued_d;
    end
  end

  assign bus.cmd_ready          = !fifo_full;
  assign bus.cpu_go             = cpu_go_q;
  assign bus.cpu_new_max        = cpu_new_max_q;
  assign bus.cpu_client_id      = cpu_id_q;
  assign bus.cpu_amount         = cpu_amt_q;
  assign bus.exchange_go        = exch_go_q;
  assign bus.exchange_client_id = exch_id_q;
  assign bus.exchange_amount    = exch_amt_q;
  assign bus.exchange_sat       = exch_sat_q;
  assign bus.issued_count       = issued_q;

endmodule

// File: tb/tb_order_stream_tx.sv
// Scoreboard bench for order_stream_tx: commands are queued as they are accepted
// and a negedge monitor checks every go pulse against them in order.
`timescale 1ns/1ps
module tb_order_stream_tx;
  import order_stream_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int GO_GAP     = 3;

  typedef struct {
    logic        is_ex;
    logic        new_max;
    logic [4:0]  id;
    logic [31:0] cpu_amt;
    logic [15:0] ex_amt;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  order_stream_tx_if bus();

  order_stream_tx #(.FIFO_DEPTH(FIFO_DEPTH), .GO_GAP(GO_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  int unsigned go_cyc[$];

  logic        m_cpu_nm;
  logic [4:0]  m_cpu_id;
  logic [31:0] m_cpu_amt;
  logic [4:0]  m_ex_id;
  logic [15:0] m_ex_amt;
  logic [15:0] m_count;

  always @(negedge clk) begin
    if (!rst && (bus.cpu_go || bus.exchange_go)) begin
      exp_t e;
      go_cyc.push_back(cyc);
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_go: cpu_go=%0b exchange_go=%0b, required no go (nothing outstanding)",
                 bus.cpu_go, bus.exchange_go);
      end else begin
        e = sb.pop_front();
        m_count = m_count + 16'd1;
        if (e.is_ex) begin
          m_ex_id  = e.id;
          m_ex_amt = e.ex_amt;
        end else begin
          m_cpu_nm  = e.new_max;
          m_cpu_id  = e.id;
          m_cpu_amt = e.cpu_amt;
        end
        if ({bus.cpu_go, bus.exchange_go} !== {!e.is_ex, e.is_ex}) begin
          n_fail++;
          $display("FAIL go_channel: cpu_go/exchange_go=%b, required %b",
                   {bus.cpu_go, bus.exchange_go}, {!e.is_ex, e.is_ex});
        end
        n_checks++;
        if ({bus.cpu_new_max, bus.cpu_client_id, bus.cpu_amount} !== {m_cpu_nm, m_cpu_id, m_cpu_amt}) begin
          n_fail++;
          $display("FAIL cpu_data: nm=%0b id=%0d amt=%h, required nm=%0b id=%0d amt=%h",
                   bus.cpu_new_max, bus.cpu_client_id, bus.cpu_amount, m_cpu_nm, m_cpu_id, m_cpu_amt);
        end
        n_checks++;
        if ({bus.exchange_client_id, bus.exchange_amount} !== {m_ex_id, m_ex_amt}) begin
          n_fail++;
          $display("FAIL exchange_data: id=%0d amt=%h, required id=%0d amt=%h",
                   bus.exchange_client_id, bus.exchange_amount, m_ex_id, m_ex_amt);
        end
        n_checks++;
        if (bus.exchange_sat !== (e.is_ex & e.sat)) begin
          n_fail++;
          $display("FAIL exchange_sat: got %0b, required %0b", bus.exchange_sat, e.is_ex & e.sat);
        end
        n_checks++;
        if (bus.issued_count !== m_count) begin
          n_fail++;
          $display("FAIL issued_count: got %h, required %h", bus.issued_count, m_count);
        end
      end
    end
  end

  // Asserts reset at the current negedge and restarts the scoreboard model.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    go_cyc.delete();
    m_cpu_nm = 1'b0; m_cpu_id = '0; m_cpu_amt = '0;
    m_ex_id = '0; m_ex_amt = '0; m_count = '0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic is_ex, input logic nm, input logic [4:0] id,
                          input logic [31:0] amt, input int budget,
                          output int unsigned acc_edge, output bit ok);
    exp_t e;
    int   waited = 0;
    bus.cmd_valid = 1'b1; bus.cmd_is_exchange = is_ex; bus.cmd_new_max = nm;
    bus.cmd_client_id = id; bus.cmd_amount = amt;
    while (!bus.cmd_ready && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    ok = bus.cmd_ready;
    acc_edge = 0;
    if (!ok) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    e.is_ex = is_ex; e.new_max = nm; e.id = id; e.cpu_amt = amt;
    e.sat = (amt > 32'h0000_FFFF);
    e.ex_amt = e.sat ? 16'hFFFF : amt[15:0];
    sb.push_back(e);
    @(negedge clk);
    acc_edge = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_gos(input int n, input int budget, output bit ok);
    int w = 0;
    while (go_cyc.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    ok = (go_cyc.size() >= n);
  endtask

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if ({bus.cpu_go, bus.cpu_new_max, bus.cpu_client_id, bus.cpu_amount, bus.exchange_go,
         bus.exchange_client_id, bus.exchange_amount, bus.exchange_sat, bus.issued_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: some output nonzero after reset, required all 0");
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%0b, required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_single_cpu();
    int unsigned k;
    bit ok;
    go_cyc.delete();
    push_cmd(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5, k, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_accept: cmd_ready never high, required acceptance"); end
    wait_gos(1, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_go_timeout: no go within 10 cycles, required one");
    end else begin
      n_checks++;
      if (go_cyc[0] !== k + 2) begin
        n_fail++;
        $display("FAIL single_latency: go at edge %0d, required edge %0d", go_cyc[0], k + 2);
      end
    end
    repeat (GO_GAP + 3) @(negedge clk);
  endtask

  task automatic test_exchange_sat();
    int unsigned k;
    bit ok;
    go_cyc.delete();
    push_cmd(1'b1, 1'b1, 5'd7, 32'h0001_0000, 5, k, ok);
    wait_gos(1, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sat_go_timeout: no go for amount 0x10000, required one"); end
    repeat (GO_GAP + 3) @(negedge clk);
    push_cmd(1'b1, 1'b0, 5'd9, 32'h0000_FFFF, 5, k, ok);
    wait_gos(2, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL nosat_go_timeout: no go for amount 0xFFFF, required one"); end
    repeat (GO_GAP + 3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int unsigned k;
    bit ok;
    logic [31:0] amts [5] = '{32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_0042, 32'hFFFF_FFFF, 32'h0000_ABCD};
    go_cyc.delete();
    push_cmd(1'b0, 1'b0, 5'd1, 32'h0000_0001, 5, k, ok);
    for (int i = 0; i < 5; i++) begin
      push_cmd(i[0], ~i[0], 5'(10 + i), amts[i], 12, k, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b_accept_%0d: not accepted within budget", i); end
      if (i == 3) begin
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_full: cmd_ready=%0b after fourth push, required 0", bus.cmd_ready);
        end
      end
    end
    wait_gos(6, 60, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_timeout: %0d go pulses seen, required 6", go_cyc.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_checks++;
        if (go_cyc[i] - go_cyc[i-1] !== GO_GAP + 1) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: gap %0d cycles, required %0d", i, go_cyc[i] - go_cyc[i-1], GO_GAP + 1);
        end
      end
    end
    repeat (GO_GAP + 3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int unsigned k;
    bit ok;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 1'b0, 5'(20 + i), 32'(i * 1000), 5, k, ok);
    do_reset(2);
    n_checks++;
    if ({bus.cpu_go, bus.cpu_new_max, bus.cpu_client_id, bus.cpu_amount, bus.exchange_go,
         bus.exchange_client_id, bus.exchange_amount, bus.exchange_sat, bus.issued_count} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: some output nonzero after reset, required all 0");
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: cmd_ready=%0b, required 1", bus.cmd_ready);
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if (go_cyc.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: %0d go pulses after reset, required 0", go_cyc.size());
    end
    push_cmd(1'b0, 1'b0, 5'd31, 32'hCAFE_0000, 5, k, ok);
    wait_gos(1, 10, ok);
    n_checks++;
    if (!ok || go_cyc[0] !== k + 2) begin
      n_fail++;
      $display("FAIL midreset_restart: go seen=%0b, required go at edge %0d", ok, k + 2);
    end
    repeat (GO_GAP + 3) @(negedge clk);
  endtask

  task automatic test_wrap();
    int unsigned k;
    bit ok;
    go_cyc.delete();
    force dut.issued_q = 16'hFFFF;
    @(negedge clk);
    release dut.issued_q;
    m_count = 16'hFFFF;
    push_cmd(1'b1, 1'b0, 5'd2, 32'h0000_0010, 5, k, ok);
    wait_gos(1, 10, ok);
    n_checks++;
    if (!ok || bus.issued_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL count_wrap: issued_count=%h, required 0000", bus.issued_count);
    end
    repeat (GO_GAP + 3) @(negedge clk);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_is_exchange = 1'b0; bus.cmd_new_max = 1'b0;
    bus.cmd_client_id = '0; bus.cmd_amount = '0;
    test_reset();
    test_single_cpu();
    test_exchange_sat();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d commands never issued, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
